// File: rtl/axi_spsram_memory_pkg.sv
// Shared AXI field widths, burst/response encodings and controller states
// for the single-port SRAM slave.
package axi_spsram_memory_pkg;

    localparam int BW_ALEN   = 4;
    localparam int BW_ASIZE  = 3;
    localparam int BW_ABURST = 2;
    localparam int BW_RESP   = 2;

    typedef enum logic [BW_ABURST-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [BW_RESP-1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RREAD,
        ST_RDATA
    } state_e;

endpackage

// File: rtl/axi_spsram_memory_if.sv
// AXI3 five-channel bundle between a master and the SRAM slave.
interface axi_spsram_memory_if #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 16
);
    import axi_spsram_memory_pkg::*;

    logic [BW_AXI_TID-1:0] rxawid;
    logic [BW_ADDR-1:0]    rxawaddr;
    logic [BW_ALEN-1:0]    rxawlen;
    logic [BW_ASIZE-1:0]   rxawsize;
    logic [BW_ABURST-1:0]  rxawburst;
    logic                  rxawvalid;
    logic                  rxawready;

    logic [BW_AXI_TID-1:0] rxwid;
    logic [BW_DATA-1:0]    rxwdata;
    logic [BW_DATA/8-1:0]  rxwstrb;
    logic                  rxwlast;
    logic                  rxwvalid;
    logic                  rxwready;

    logic [BW_AXI_TID-1:0] rxbid;
    logic [BW_RESP-1:0]    rxbresp;
    logic                  rxbvalid;
    logic                  rxbready;

    logic [BW_AXI_TID-1:0] rxarid;
    logic [BW_ADDR-1:0]    rxaraddr;
    logic [BW_ALEN-1:0]    rxarlen;
    logic [BW_ASIZE-1:0]   rxarsize;
    logic [BW_ABURST-1:0]  rxarburst;
    logic                  rxarvalid;
    logic                  rxarready;

    logic [BW_AXI_TID-1:0] rxrid;
    logic [BW_DATA-1:0]    rxrdata;
    logic [BW_RESP-1:0]    rxrresp;
    logic                  rxrlast;
    logic                  rxrvalid;
    logic                  rxrready;

    modport slave (
        input  rxawid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawvalid,
        output rxawready,
        input  rxwid, rxwdata, rxwstrb, rxwlast, rxwvalid,
        output rxwready,
        output rxbid, rxbresp, rxbvalid,
        input  rxbready,
        input  rxarid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarvalid,
        output rxarready,
        output rxrid, rxrdata, rxrresp, rxrlast, rxrvalid,
        input  rxrready
    );

    modport master (
        output rxawid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawvalid,
        input  rxawready,
        output rxwid, rxwdata, rxwstrb, rxwlast, rxwvalid,
        input  rxwready,
        input  rxbid, rxbresp, rxbvalid,
        output rxbready,
        output rxarid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarvalid,
        input  rxarready,
        input  rxrid, rxrdata, rxrresp, rxrlast, rxrvalid,
        output rxrready
    );

endinterface

// File: rtl/axi_spsram_memory_cell.sv
// Byte-lane-writable word storage with a registered read port; the read
// register only changes on re, so data stays put while the bus stalls.
module memory_cell_1r1w #(
    parameter int  DEPTH = 1024,
    parameter int  WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH/8-1:0] we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Only the output register is cleared; the array itself keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_spsram_memory.sv
// AXI3 slave in front of a single-port SRAM: one burst in flight at a time,
// alternating write/read priority, 32-bit words with byte strobes.
module axi_spsram_memory
    import axi_spsram_memory_pkg::*;
#(
    parameter int                 BW_ADDR    = 32,
    parameter int                 BW_DATA    = 32,
    parameter int                 BW_AXI_TID = 16,
    parameter logic [BW_ADDR-1:0] BASEADDR   = '0,
    parameter int                 CELL_SIZE  = 4096
) (
    input logic                clk,
    input logic                rst,
    input logic                enable,
    axi_spsram_memory_if.slave bus
);

    localparam int DEPTH = CELL_SIZE / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q, state_d;
    logic [BW_AXI_TID-1:0] id_q, id_d;
    logic [BW_ADDR-1:0]    addr_q, addr_d;
    logic [BW_ALEN-1:0]    len_q, len_d;
    logic [BW_ALEN-1:0]    beat_q, beat_d;
    burst_e                burst_q, burst_d;
    logic                  wprio_q, wprio_d;

    logic [BW_DATA/8-1:0]  mem_we;
    logic                  mem_re;
    logic [AW-1:0]         mem_idx;
    logic [BW_DATA-1:0]    mem_rdata;
    logic                  grant_w, grant_r, accept;
    logic                  unused_bus_fields;

    function automatic logic [AW-1:0] word_index(input logic [BW_ADDR-1:0] addr);
        logic [BW_ADDR-1:0] word;
        word = (addr - BASEADDR) >> 2;
        return AW'(word % BW_ADDR'(DEPTH));
    endfunction

    // WRAP keeps the bits above the (len+1)*4 window and wraps only the offset.
    function automatic logic [BW_ADDR-1:0] next_addr(input logic [BW_ADDR-1:0] addr,
                                                     input logic [BW_ALEN-1:0] len,
                                                     input burst_e             burst);
        logic [BW_ADDR-1:0] mask;
        logic [BW_ADDR-1:0] step;
        logic [BW_ADDR-1:0] result;
        mask = BW_ADDR'({len, 2'b11});
        step = addr + BW_ADDR'(4);
        case (burst)
            BURST_FIXED: result = addr;
            BURST_WRAP:  result = (addr & ~mask) | (step & mask);
            default:     result = step;
        endcase
        return result;
    endfunction

    assign unused_bus_fields = ^{bus.rxawsize, bus.rxarsize, bus.rxwid, bus.rxwlast};

    assign grant_w = bus.rxawvalid && (!bus.rxarvalid || wprio_q);
    assign grant_r = bus.rxarvalid && !grant_w;
    assign accept  = (state_q == ST_IDLE) && enable && !rst;
    assign mem_idx = word_index(addr_q);

    assign bus.rxbid   = id_q;
    assign bus.rxrid   = id_q;
    assign bus.rxbresp = RESP_OKAY;
    assign bus.rxrresp = RESP_OKAY;
    assign bus.rxrdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset favours the write channel on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= BURST_INCR;
            wprio_q <= 1'b1;
        end else begin
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            wprio_q <= wprio_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        burst_d       = burst_q;
        wprio_d       = wprio_q;
        mem_we        = '0;
        mem_re        = 1'b0;
        bus.rxawready = 1'b0;
        bus.rxarready = 1'b0;
        bus.rxwready  = 1'b0;
        bus.rxbvalid  = 1'b0;
        bus.rxrvalid  = 1'b0;
        bus.rxrlast   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bus.rxawready = grant_w;
                    bus.rxarready = grant_r;
                    if (grant_w) begin
                        id_d    = bus.rxawid;
                        addr_d  = bus.rxawaddr;
                        len_d   = bus.rxawlen;
                        burst_d = burst_e'(bus.rxawburst);
                        beat_d  = '0;
                        wprio_d = 1'b0;
                        state_d = ST_WDATA;
                    end else if (grant_r) begin
                        id_d    = bus.rxarid;
                        addr_d  = bus.rxaraddr;
                        len_d   = bus.rxarlen;
                        burst_d = burst_e'(bus.rxarburst);
                        beat_d  = '0;
                        wprio_d = 1'b1;
                        state_d = ST_RREAD;
                    end
                end
            end
            ST_WDATA: begin
                bus.rxwready = 1'b1;
                if (bus.rxwvalid) begin
                    mem_we = bus.rxwstrb;
                    addr_d = next_addr(addr_q, len_q, burst_q);
                    beat_d = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                bus.rxbvalid = 1'b1;
                if (bus.rxbready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RREAD: begin
                mem_re  = 1'b1;
                addr_d  = next_addr(addr_q, len_q, burst_q);
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                bus.rxrvalid = 1'b1;
                bus.rxrlast  = (beat_q == len_q);
                // Prefetch the next word on the handshake so beats stay back to back.
                if (bus.rxrready) begin
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        mem_re = 1'b1;
                        addr_d = next_addr(addr_q, len_q, burst_q);
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    memory_cell_1r1w #(
        .DEPTH(DEPTH),
        .WIDTH(BW_DATA)
    ) u_cell (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(mem_idx),
        .wdata(bus.rxwdata),
        .re   (mem_re),
        .raddr(mem_idx),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_axi_spsram_memory.sv
// Scoreboard bench for axi_spsram_memory: a bench-side memory model predicts
// every read beat, which is queued at issue time and compared on arrival.
module tb_axi_spsram_memory;
    import axi_spsram_memory_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [15:0] id;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_spsram_memory_if #(.BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(16)) bus ();

    axi_spsram_memory #(
        .BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(16), .BASEADDR(32'h0), .CELL_SIZE(4096)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus)
    );

    rbeat_t      exp_q[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [15:0] got_id[$];
    logic [1:0]  got_resp[$];
    logic [31:0] stall_data[$];
    logic        stall_valid[$];
    logic [31:0] model_mem[int];
    logic [31:0] wr_data[16];
    logic [3:0]  wr_strb[16];
    int          aw_hs_cyc, ar_hs_cyc, first_r_cyc;

    // Independent address model: wrap window found by division, not masking.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] wb;
        logic [31:0] base;
        if (burst == 2'd0) return a;
        if (burst == 2'd2) begin
            wb   = 32'(len + 1) * 32'd4;
            base = a - (a % wb);
            return base + ((a - base + 32'(4 * i)) % wb);
        end
        return a + 32'(4 * i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    task automatic model_write(input logic [31:0] a, input int len, input logic [1:0] burst);
        for (int i = 0; i <= len; i++) begin
            int          k;
            logic [31:0] w;
            k = widx(beat_addr(a, len, burst, i));
            w = model_mem.exists(k) ? model_mem[k] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[i][b]) w[b*8 +: 8] = wr_data[i][b*8 +: 8];
            end
            model_mem[k] = w;
        end
    endtask

    task automatic push_expected(input logic [31:0] a, input int len, input logic [1:0] burst,
                                 input logic [15:0] id);
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back('{model_mem[widx(beat_addr(a, len, burst, i))], (i == len), id});
        end
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] burst,
                            input logic [15:0] id, output logic [15:0] bid,
                            output logic [1:0] bresp, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        bus.rxawid = id; bus.rxawaddr = a; bus.rxawlen = 4'(len);
        bus.rxawsize = 3'd2; bus.rxawburst = burst; bus.rxawvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.rxawready && n < 100) begin @(negedge clk); #1; n++; end
        if (!bus.rxawready) ok = 1'b0;
        aw_hs_cyc = cyc;
        @(posedge clk); #1;
        bus.rxawvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            bus.rxwid = id; bus.rxwdata = wr_data[i]; bus.rxwstrb = wr_strb[i];
            bus.rxwlast = (i == len); bus.rxwvalid = 1'b1;
            #1;
            n = 0;
            while (!bus.rxwready && n < 100) begin @(negedge clk); #1; n++; end
            if (!bus.rxwready) ok = 1'b0;
            @(posedge clk); #1;
            bus.rxwvalid = 1'b0;
        end
        bus.rxbready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.rxbvalid && n < 100) begin @(negedge clk); n++; end
        if (!bus.rxbvalid) ok = 1'b0;
        bid = bus.rxbid;
        bresp = bus.rxbresp;
        @(posedge clk); #1;
        bus.rxbready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] burst,
                           input logic [15:0] id, input int stall_at, input int stall_cycles,
                           output bit ok);
        int n, beats, stall_left;
        bit stalled, first, done;
        ok = 1'b1;
        got_data.delete(); got_last.delete(); got_id.delete(); got_resp.delete();
        stall_data.delete(); stall_valid.delete();
        first_r_cyc = -1;
        @(negedge clk);
        bus.rxarid = id; bus.rxaraddr = a; bus.rxarlen = 4'(len);
        bus.rxarsize = 3'd2; bus.rxarburst = burst; bus.rxarvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.rxarready && n < 100) begin @(negedge clk); #1; n++; end
        if (!bus.rxarready) ok = 1'b0;
        ar_hs_cyc = cyc;
        @(posedge clk); #1;
        bus.rxarvalid = 1'b0;
        bus.rxrready = 1'b1;
        beats = 0; stall_left = stall_cycles; stalled = 1'b0; first = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (bus.rxrvalid && first) begin first_r_cyc = cyc; first = 1'b0; end
            if (stall_left > 0 && beats == stall_at && (bus.rxrvalid || stalled)) begin
                stalled = 1'b1;
                bus.rxrready = 1'b0;
                stall_data.push_back(bus.rxrdata);
                stall_valid.push_back(bus.rxrvalid);
                stall_left--;
            end else if (bus.rxrvalid) begin
                bus.rxrready = 1'b1;
                got_data.push_back(bus.rxrdata);
                got_last.push_back(bus.rxrlast);
                got_id.push_back(bus.rxrid);
                got_resp.push_back(bus.rxrresp);
                beats++;
                if (bus.rxrlast) done = 1'b1;
            end
            n++;
        end
        if (!done) ok = 1'b0;
        @(posedge clk); #1;
        bus.rxrready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        bus.rxawvalid = 1'b1; bus.rxarvalid = 1'b1; bus.rxwvalid = 1'b1;
        bus.rxbready = 1'b1; bus.rxrready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.rxawready, bus.rxarready, bus.rxwready, bus.rxbvalid, bus.rxrvalid, bus.rxrlast} !== 6'b0)
            $display("[TB] FAIL reset_handshake: got aw/ar/w/b/r/last=%b expected 000000",
                     {bus.rxawready, bus.rxarready, bus.rxwready, bus.rxbvalid, bus.rxrvalid, bus.rxrlast});
        else passed++;
        checks++;
        if ({bus.rxrdata, bus.rxrid, bus.rxbid, bus.rxrresp, bus.rxbresp} !== 68'h0)
            $display("[TB] FAIL reset_fields: got rdata=%h rid=%h bid=%h rresp=%0d bresp=%0d expected all 0",
                     bus.rxrdata, bus.rxrid, bus.rxbid, bus.rxrresp, bus.rxbresp);
        else passed++;
        bus.rxawvalid = 1'b0; bus.rxarvalid = 1'b0; bus.rxwvalid = 1'b0;
        bus.rxbready = 1'b0; bus.rxrready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok_w, ok_r;
        int          k;
        wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
        model_write(32'h40, 0, 2'd1);
        push_expected(32'h40, 0, 2'd1, 16'h00B2);
        fork
            do_write(32'h40, 0, 2'd1, 16'h00A1, bid, bresp, ok_w);
            do_read(32'h40, 0, 2'd1, 16'h00B2, -1, 0, ok_r);
        join
        checks++;
        if (!(ok_w && ok_r)) $display("[TB] FAIL simul_timeout: got ok_w=%b ok_r=%b expected 1 1", ok_w, ok_r);
        else passed++;
        checks++;
        if (!(aw_hs_cyc < ar_hs_cyc))
            $display("[TB] FAIL simul_order: got aw cycle %0d ar cycle %0d expected aw before ar", aw_hs_cyc, ar_hs_cyc);
        else passed++;
        checks++;
        if ({bid, bresp} !== {16'h00A1, 2'b00})
            $display("[TB] FAIL simul_bresp: got bid=%h bresp=%0d expected bid=00a1 bresp=0", bid, bresp);
        else passed++;
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL simul_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL simul_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    task automatic test_single();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        int          k;
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        model_write(32'h10, 0, 2'd1);
        do_write(32'h10, 0, 2'd1, 16'h1234, bid, bresp, ok);
        checks++;
        if (!ok || {bid, bresp} !== {16'h1234, 2'b00})
            $display("[TB] FAIL single_bresp: got ok=%b bid=%h bresp=%0d expected ok=1 bid=1234 bresp=0", ok, bid, bresp);
        else passed++;
        push_expected(32'h10, 0, 2'd1, 16'h0BAD);
        do_read(32'h10, 0, 2'd1, 16'h0BAD, -1, 0, ok);
        checks++;
        if (!ok || (first_r_cyc - ar_hs_cyc) != 2)
            $display("[TB] FAIL single_latency: got ok=%b latency=%0d expected ok=1 latency=2", ok, first_r_cyc - ar_hs_cyc);
        else passed++;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'hDEADBEEF)
            $display("[TB] FAIL single_const: got %0d beats first=%h expected 1 beat deadbeef",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        else passed++;
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL single_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL single_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    task automatic test_incr_burst();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        int          k;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        model_write(32'h100, 3, 2'd1);
        do_write(32'h100, 3, 2'd1, 16'h0007, bid, bresp, ok);
        checks++;
        if (!ok || {bid, bresp} !== {16'h0007, 2'b00})
            $display("[TB] FAIL incr_bresp: got ok=%b bid=%h bresp=%0d expected ok=1 bid=0007 bresp=0", ok, bid, bresp);
        else passed++;
        push_expected(32'h100, 3, 2'd1, 16'h0008);
        do_read(32'h100, 3, 2'd1, 16'h0008, -1, 0, ok);
        checks++;
        if (!ok || got_data.size() != 4)
            $display("[TB] FAIL incr_count: got ok=%b beats=%0d expected ok=1 beats=4", ok, got_data.size());
        else passed++;
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL incr_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL incr_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    task automatic test_strobe();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        model_write(32'h20, 0, 2'd1);
        do_write(32'h20, 0, 2'd1, 16'h0001, bid, bresp, ok);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'h5;
        model_write(32'h20, 0, 2'd1);
        do_write(32'h20, 0, 2'd1, 16'h0002, bid, bresp, ok);
        push_expected(32'h20, 0, 2'd1, 16'h0003);
        do_read(32'h20, 0, 2'd1, 16'h0003, -1, 0, ok);
        checks++;
        if (!ok || got_data.size() != 1 || got_data[0] !== 32'h11BB33DD)
            $display("[TB] FAIL strobe_merge: got ok=%b beats=%0d data=%h expected ok=1 beats=1 data=11bb33dd",
                     ok, got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        else passed++;
        if (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (got_data.size() == 0 || {got_data[0], got_last[0], got_id[0]} !== {e.data, e.last, e.id})
                $display("[TB] FAIL strobe_beat0: got data=%h expected data=%h last=%b id=%h",
                         (got_data.size() > 0) ? got_data[0] : 32'hx, e.data, e.last, e.id);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        int          k;
        logic [31:0] want[4];
        want[0] = 32'hC0C0C0C0; want[1] = 32'hD0D0D0D0; want[2] = 32'hA0A0A0A0; want[3] = 32'hB0B0B0B0;
        wr_data[0] = 32'hA0A0A0A0; wr_data[1] = 32'hB0B0B0B0;
        wr_data[2] = 32'hC0C0C0C0; wr_data[3] = 32'hD0D0D0D0;
        for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
        model_write(32'h100, 3, 2'd1);
        do_write(32'h100, 3, 2'd1, 16'h0011, bid, bresp, ok);
        push_expected(32'h108, 3, 2'd2, 16'h0022);
        do_read(32'h108, 3, 2'd2, 16'h0022, -1, 0, ok);
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL wrap_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00}
                     || got_data[k] !== want[k])
                $display("[TB] FAIL wrap_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        int          k;
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h5000_0000 + 32'(i * 17); wr_strb[i] = 4'hF; end
        model_write(32'h300, 3, 2'd1);
        do_write(32'h300, 3, 2'd1, 16'h0030, bid, bresp, ok);
        push_expected(32'h300, 3, 2'd1, 16'h0031);
        do_read(32'h300, 3, 2'd1, 16'h0031, 1, 5, ok);
        checks++;
        if (stall_data.size() != 5) $display("[TB] FAIL stall_count: got %0d stall samples expected 5", stall_data.size());
        else passed++;
        for (int i = 0; i < stall_data.size(); i++) begin
            checks++;
            if (stall_valid[i] !== 1'b1 || stall_data[i] !== wr_data[1])
                $display("[TB] FAIL stall_hold%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, stall_valid[i], stall_data[i], wr_data[1]);
            else passed++;
        end
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL stall_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL stall_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    task automatic test_alias();
        logic [15:0] bid;
        logic [1:0]  bresp;
        bit          ok;
        wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
        model_write(32'h1050, 0, 2'd1);
        do_write(32'h1050, 0, 2'd1, 16'h0040, bid, bresp, ok);
        push_expected(32'h50, 0, 2'd1, 16'h0041);
        do_read(32'h50, 0, 2'd1, 16'h0041, -1, 0, ok);
        if (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (!ok || got_data.size() != 1 || {got_data[0], got_last[0], got_id[0], got_resp[0]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL alias_beat0: got ok=%b beats=%0d data=%h expected data=%h id=%h",
                         ok, got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx, e.data, e.id);
            else passed++;
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        @(negedge clk);
        bus.rxawid = 16'h0099; bus.rxawaddr = 32'h60; bus.rxawlen = 4'd0;
        bus.rxawburst = 2'd1; bus.rxawvalid = 1'b1;
        bus.rxarid = 16'h0098; bus.rxaraddr = 32'h60; bus.rxarlen = 4'd0;
        bus.rxarburst = 2'd1; bus.rxarvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.rxawready, bus.rxarready} !== 2'b00)
            $display("[TB] FAIL enable_block: got awready=%b arready=%b expected 0 0", bus.rxawready, bus.rxarready);
        else passed++;
        bus.rxawvalid = 1'b0; bus.rxarvalid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        bit seen_b;
        bit ok;
        int n, k;
        wr_data[0] = 32'h5A5A0001; wr_data[1] = 32'h5A5A0002;
        wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        model_write(32'h200, 1, 2'd1);
        @(negedge clk);
        bus.rxawid = 16'h0050; bus.rxawaddr = 32'h200; bus.rxawlen = 4'd3;
        bus.rxawburst = 2'd1; bus.rxawvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.rxawready && n < 100) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.rxawvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.rxwdata = wr_data[i]; bus.rxwstrb = 4'hF; bus.rxwvalid = 1'b1;
            #1;
            n = 0;
            while (!bus.rxwready && n < 100) begin @(negedge clk); #1; n++; end
            @(posedge clk); #1;
            bus.rxwvalid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        bus.rxbready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen_b = 1'b0;
        repeat (5) begin @(negedge clk); if (bus.rxbvalid) seen_b = 1'b1; end
        bus.rxbready = 1'b0;
        checks++;
        if (seen_b) $display("[TB] FAIL midrst_no_b: got bvalid=1 after reset expected 0");
        else passed++;
        push_expected(32'h200, 1, 2'd1, 16'h0051);
        do_read(32'h200, 1, 2'd1, 16'h0051, -1, 0, ok);
        k = 0;
        while (exp_q.size() > 0) begin
            rbeat_t e;
            e = exp_q.pop_front();
            checks++;
            if (k >= got_data.size()) $display("[TB] FAIL midrst_beat%0d: got no beat expected data=%h", k, e.data);
            else if ({got_data[k], got_last[k], got_id[k], got_resp[k]} !== {e.data, e.last, e.id, 2'b00})
                $display("[TB] FAIL midrst_beat%0d: got data=%h last=%b id=%h resp=%0d expected data=%h last=%b id=%h resp=0",
                         k, got_data[k], got_last[k], got_id[k], got_resp[k], e.data, e.last, e.id);
            else passed++;
            k++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        bus.rxawid = '0; bus.rxawaddr = '0; bus.rxawlen = '0; bus.rxawsize = 3'd2;
        bus.rxawburst = 2'd1; bus.rxawvalid = 1'b0;
        bus.rxwid = '0; bus.rxwdata = '0; bus.rxwstrb = '0; bus.rxwlast = 1'b0; bus.rxwvalid = 1'b0;
        bus.rxbready = 1'b0;
        bus.rxarid = '0; bus.rxaraddr = '0; bus.rxarlen = '0; bus.rxarsize = 3'd2;
        bus.rxarburst = 2'd1; bus.rxarvalid = 1'b0;
        bus.rxrready = 1'b0;
        $display("[TB] starting axi_spsram_memory bench");
        test_reset();
        test_simultaneous();
        test_single();
        test_incr_burst();
        test_strobe();
        test_wrap();
        test_backpressure();
        test_alias();
        test_enable();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
